// File: rtl/fixed_mult_scheduler.sv
// -----------------------------------------------------------------------------
// fixed_mult_scheduler
//
// Round-robin scheduler that shares a single combinational fixed-point
// multiplier between n_req requesters. A granted operand pair is registered
// (stage 1), multiplied, and the product registered (stage 2) together with
// the owning requester index. Sustains one operation per cycle; a handshake
// in cycle T returns its product in cycle T+2.
//
// Ports:
//   clk        in   single clock, all state on the rising edge
//   rst        in   synchronous active-high reset
//   hold       in   suppresses new grants; in-flight ops still complete
//   req_valid  in   [n_req]              per-requester operand pair available
//   req_a      in   [n_req*operand_size] per-requester operand a (slot i at i*operand_size)
//   req_b      in   [n_req*operand_size] per-requester operand b
//   req_ready  out  [n_req]              one-hot-or-zero grant
//   rsp_valid  out  [n_req]              one-hot-or-zero response pulse to owner
//   rsp_id     out  [id_w]               index of the requester owning rsp_c
//   rsp_c      out  [operand_size]       product (holds when no response)
//   busy       out  high while either pipeline stage holds a valid op
//
// Also contains fixed_multiply, the combinational signed Q-format multiplier
// that the scheduler instantiates once.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// fixed_multiply
//
// Signed fixed-point multiply with fractional_size fraction bits. Operands
// are sign-extended to operand_size+fractional_size bits, multiplied modulo
// that width, and the result is the window starting at the fraction point:
// truncation toward -inf, wrap on overflow, no saturation.
//
// Ports:
//   a  in   [operand_size]  multiplicand
//   b  in   [operand_size]  multiplier
//   c  out  [operand_size]  product
// -----------------------------------------------------------------------------
module fixed_multiply #(
    parameter int fractional_size = 12,
    parameter int operand_size    = 32
) (
    input  logic [operand_size-1:0] a,
    input  logic [operand_size-1:0] b,
    output logic [operand_size-1:0] c
);
    localparam int PROD_W = operand_size + fractional_size;

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] prod;

    assign a_ext = {{fractional_size{a[operand_size-1]}}, a};
    assign b_ext = {{fractional_size{b[operand_size-1]}}, b};
    assign prod  = a_ext * b_ext;

    // Arithmetic shift drops the fraction bits (floor); the cast keeps the
    // low operand_size bits, which wraps any overflow.
    assign c = operand_size'(prod >>> fractional_size);
endmodule

module fixed_mult_scheduler #(
    parameter  int fractional_size = 12,
    parameter  int operand_size    = 32,
    parameter  int n_req           = 4,
    localparam int id_w            = $clog2(n_req)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hold,
    input  logic [n_req-1:0]              req_valid,
    input  logic [n_req*operand_size-1:0] req_a,
    input  logic [n_req*operand_size-1:0] req_b,
    output logic [n_req-1:0]              req_ready,
    output logic [n_req-1:0]              rsp_valid,
    output logic [id_w-1:0]               rsp_id,
    output logic [operand_size-1:0]       rsp_c,
    output logic                          busy
);
    // Control state
    logic [id_w-1:0]         ptr_q,   ptr_d;
    logic                    s1_v_q,  s1_v_d;
    logic                    s2_v_q,  s2_v_d;
    // Data state
    logic [operand_size-1:0] s1_a_q,  s1_a_d;
    logic [operand_size-1:0] s1_b_q,  s1_b_d;
    logic [id_w-1:0]         s1_id_q, s1_id_d;
    logic [operand_size-1:0] s2_c_q,  s2_c_d;
    logic [id_w-1:0]         s2_id_q, s2_id_d;

    // Arbitration results
    logic                    grant_any;
    logic [id_w-1:0]         grant_id;
    logic [operand_size-1:0] grant_a;
    logic [operand_size-1:0] grant_b;
    logic [operand_size-1:0] mult_c;
    int                      scan_idx;

    // Round-robin search from ptr_q, wrapping modulo n_req. The first valid
    // requester wins; hold masks the grant but keeps the search result unused.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = 0;
        for (int k = 0; k < n_req; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= n_req) begin
                scan_idx = scan_idx - n_req;
            end
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_id  = id_w'(scan_idx);
            end
        end
        if (hold) begin
            grant_any = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign grant_a = req_a[grant_id*operand_size +: operand_size];
    assign grant_b = req_b[grant_id*operand_size +: operand_size];

    // A grant is always a handshake because only valid requesters are granted.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_id == id_w'(n_req - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // ---- stage 0 -> stage 1: capture granted operands ----
    always_comb begin
        s1_v_d  = grant_any;
        s1_a_d  = grant_any ? grant_a  : s1_a_q;
        s1_b_d  = grant_any ? grant_b  : s1_b_q;
        s1_id_d = grant_any ? grant_id : s1_id_q;
    end

    fixed_multiply #(
        .fractional_size (fractional_size),
        .operand_size    (operand_size)
    ) u_mult (
        .a (s1_a_q),
        .b (s1_b_q),
        .c (mult_c)
    );

    // ---- stage 1 -> stage 2: register product; hold last result when idle ----
    always_comb begin
        s2_v_d  = s1_v_q;
        s2_c_d  = s1_v_q ? mult_c  : s2_c_q;
        s2_id_d = s1_v_q ? s1_id_q : s2_id_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            s1_id_q <= '0;
            s2_c_q  <= '0;
            s2_id_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            s1_v_q  <= s1_v_d;
            s2_v_q  <= s2_v_d;
            s1_a_q  <= s1_a_d;
            s1_b_q  <= s1_b_d;
            s1_id_q <= s1_id_d;
            s2_c_q  <= s2_c_d;
            s2_id_q <= s2_id_d;
        end
    end

    // ---- stage 2 outputs ----
    always_comb begin
        rsp_valid = '0;
        if (s2_v_q) begin
            rsp_valid[s2_id_q] = 1'b1;
        end
    end

    assign rsp_id = s2_id_q;
    assign rsp_c  = s2_c_q;
    assign busy   = s1_v_q | s2_v_q;
endmodule
